// File: rtl/cfs_md_responder.sv
// MD-bus target: checks each transfer for legality, queues accepted transfers
// in a small FIFO and keeps saturating accept/reject counters.
module cfs_md_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int OW    = (BYTES > 1) ? $clog2(BYTES) : 1,
    localparam int SW    = $clog2(BYTES) + 1,
    localparam int LW    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  md_valid,
    input  logic [DATA_WIDTH-1:0] md_data,
    input  logic [OW-1:0]         md_offset,
    input  logic [SW-1:0]         md_size,
    output logic                  md_ready,
    output logic                  md_err,
    input  logic [3:0]            cfg_wait,
    input  logic                  clr_cnt,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [OW-1:0]         pop_offset,
    output logic [SW-1:0]         pop_size,
    output logic [LW-1:0]         fifo_lvl,
    output logic [CNT_W-1:0]      cnt_ok,
    output logic [CNT_W-1:0]      cnt_err,
    output logic                  proto_viol
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [OW-1:0]         offset;
        logic [SW-1:0]         size;
    } xfer_t;

    state_e           state_q, state_d;
    xfer_t            cap_q, cap_d, md_in, head;
    logic [3:0]       wait_q, wait_d;
    logic             ready_q, err_q, viol_q;
    logic [CNT_W-1:0] cnt_ok_q, cnt_err_q;
    xfer_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    lvl_q;

    logic             illegal, full, mismatch, viol, push, pop, resp_err;
    logic [SW:0]      span;

    assign md_in    = {md_data, md_offset, md_size};
    // One extra bit so offset+size can never wrap into a legal-looking value.
    assign span     = (SW+1)'(cap_q.offset) + (SW+1)'(cap_q.size);
    assign illegal  = (cap_q.size == '0) || (span > (SW+1)'(BYTES));
    assign full     = (lvl_q == LW'(FIFO_DEPTH));
    assign mismatch = !md_valid || (md_in != cap_q);
    assign pop      = pop_valid && pop_ready;

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        wait_d   = wait_q;
        viol     = 1'b0;
        push     = 1'b0;
        resp_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_valid) begin
                    cap_d   = md_in;
                    wait_d  = cfg_wait;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mismatch) begin
                    viol    = 1'b1;
                    state_d = IDLE;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (!full || illegal) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (mismatch) begin
                    viol = 1'b1;
                end else begin
                    push     = !illegal;
                    resp_err = illegal;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            wait_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            wait_q  <= wait_d;
            ready_q <= (state_d == RESP);
            err_q   <= (state_d == RESP) && illegal;
            viol_q  <= viol;
        end
    end

    // Clear takes priority over any increment in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else if (clr_cnt) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            if (push && (cnt_ok_q != '1))
                cnt_ok_q <= cnt_ok_q + CNT_W'(1);
            if (resp_err && (cnt_err_q != '1))
                cnt_err_q <= cnt_err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)
                lvl_q <= lvl_q + LW'(1);
            else if (pop && !push)
                lvl_q <= lvl_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= cap_q;
    end

    assign head       = mem_q[rd_ptr_q];
    assign pop_valid  = (lvl_q != '0);
    assign pop_data   = head.data;
    assign pop_offset = head.offset;
    assign pop_size   = head.size;
    assign fifo_lvl   = lvl_q;
    assign cnt_ok     = cnt_ok_q;
    assign cnt_err    = cnt_err_q;
    assign md_ready   = ready_q;
    assign md_err     = err_q;
    assign proto_viol = viol_q;

endmodule
